// File: rtl/execute_skid_buffer.sv
// Execute-side skid buffer: two-entry FIFO between decode and execute.
// The ready path to decode comes from a flop.
package core_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  op;
   } decoded_instr_t;

endpackage

module execute_skid_buffer
   import core_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  decoded_instr_t   in_instr,
   input  logic             in_valid,
   output logic             in_ready,
   output decoded_instr_t   out_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       state_q, state_d;
   decoded_instr_t   head_q, head_d;
   decoded_instr_t   tail_q, tail_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             push, pop;

   assign out_valid    = (state_q != EMPTY);
   assign out_instr    = head_q;
   assign in_ready     = in_ready_q;
   assign occupancy    = state_q;
   assign stall_cycles = stall_q;

   assign push = in_valid && in_ready_q;
   assign pop  = out_valid && out_ready;

   // Next state, entry writes, registered ready and stall counter.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      stall_d = stall_q;

      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end

      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (push) begin
                  head_d  = in_instr;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_d = in_instr;
               end else if (push) begin
                  tail_d  = in_instr;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_d  = tail_q;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      in_ready_d = (state_d != FULL);
   end

   // State registers; reset clears everything and holds ready low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_execute_skid_buffer.sv
// Randomized and directed bench for execute_skid_buffer.
// A queue-based model predicts every output.
module tb_execute_skid_buffer;
   import core_pkg::*;

   localparam int CNT_W = 4;
   localparam int SMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   decoded_instr_t   in_instr = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   decoded_instr_t   out_instr;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cycles;

   execute_skid_buffer #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_instr     (in_instr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_instr    (out_instr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .occupancy    (occupancy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   decoded_instr_t m_q[$];
   bit             m_rdy   = 1'b0;
   int             m_stall = 0;
   bit             m_zero  = 1'b1;
   bit             started = 1'b0;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("in_ready", 128'(in_ready), 128'(m_rdy));
      chk("out_valid", 128'(out_valid), 128'(m_q.size() != 0));
      chk("occupancy", 128'(occupancy), 128'(m_q.size()));
      chk("stall", 128'(stall_cycles), 128'(m_stall));
      if (m_q.size() != 0)
         chk("out_instr", 128'(out_instr), 128'(m_q[0]));
      else if (m_zero)
         chk("out_zero", 128'(out_instr), 128'(0));
   endtask

   // One clock: update model from the handshake at the edge, then check.
   task automatic cycle();
      bit push, pop;
      @(posedge clk);
      push = in_valid && m_rdy;
      pop  = (m_q.size() != 0) && out_ready;
      if (rst) begin
         m_q.delete();
         m_rdy   = 1'b0;
         m_stall = 0;
         m_zero  = 1'b1;
         started = 1'b1;
      end else begin
         if (m_q.size() != 0 && !out_ready && m_stall != SMAX)
            m_stall++;
         if (flush) begin
            m_q.delete();
         end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
               m_q.push_back(in_instr);
               m_zero = 1'b0;
            end
         end
         m_rdy = (m_q.size() < 2);
      end
      @(negedge clk);
      if (push && !rst) in_valid = 1'b0;
      if (started) chk_all();
   endtask

   task automatic offer(input int v);
      in_instr = decoded_instr_t'(v);
      in_valid = 1'b1;
   endtask

   initial begin
      // reset then idle
      rst = 1'b1;
      repeat (3) cycle();
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      rst = 1'b0;
      cycle();
      chk("rel_in_ready", 128'(in_ready), 128'(1));
      cycle();

      // streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         offer(i);
         cycle();
      end
      cycle();
      cycle();
      chk("stream_stall", 128'(stall_cycles), 128'(0));

      // backpressure
      out_ready = 1'b0;
      offer(5); cycle();
      offer(6); cycle();
      offer(7); cycle(); cycle(); cycle();
      chk("bp_full", 128'(occupancy), 128'(2));
      chk("bp_ready", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      chk("bp_head", 128'(out_instr), 128'(5));
      repeat (4) cycle();

      // simultaneous push/pop in ONE
      out_ready = 1'b0;
      offer(8); cycle();
      out_ready = 1'b1;
      offer(9); cycle();
      chk("pp_head", 128'(out_instr), 128'(9));
      chk("pp_occ", 128'(occupancy), 128'(1));
      out_ready = 1'b1;
      cycle();

      // flush with a simultaneous push
      out_ready = 1'b0;
      offer(10); cycle();
      offer(11); cycle();
      offer(12); flush = 1'b1; cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", 128'(occupancy), 128'(0));
      chk("fl_ready", 128'(in_ready), 128'(1));
      offer(13); cycle();
      chk("fl_next", 128'(out_instr), 128'(13));

      // saturation, then rst and flush together
      repeat (20) cycle();
      chk("sat", 128'(stall_cycles), 128'(SMAX));
      rst = 1'b1; flush = 1'b1;
      cycle();
      rst = 1'b0; flush = 1'b0;
      chk("rf_stall", 128'(stall_cycles), 128'(0));
      chk("rf_instr", 128'(out_instr), 128'(0));
      cycle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (!(in_valid && !m_rdy)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = decoded_instr_t'({$urandom, $urandom, $urandom});
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 127) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
